bcout_cascade_driver: RTL and testbench
=======================================

// Module: bcout_cascade_driver
// PURPOSE
//  Transmit side of the DSP slice B-cascade. Takes the selected B source (B or BCIN).
//  Passes it through an optional B0 register and an optional D-port pre-adder, then the B1 register.
//  Drives BCOUT to the next slice's BCIN and to the local multiplier.
//  Tracks data validity through the pipeline, so downstream logic knows when BCOUT holds real data.
// PARAMETERS
//  B_INPUT  "DIRECT"  source select: "DIRECT"=B, "CASCADE"=BCIN, any other value = 18'b0
//  B0REG    1         1 = B0 stage registered, 0 = combinational bypass (nonzero treated as 1)
//  DREG     1         1 = D stage registered, 0 = bypass (nonzero treated as 1)
//  B1REG    1         1 = B1 stage registered, 0 = bypass (nonzero treated as 1)
// PORTS
//  CLK          in   1   single clock, rising edge
//  RSTN         in   1   asynchronous, active-low reset
//  CE           in   1   clock enable, common to all stages and to the valid tracker
//  B            in   18  direct B operand
//  BCIN         in   18  cascade B from the previous slice
//  D            in   18  pre-adder operand
//  IN_VALID     in   1   B/BCIN/D carry real data this cycle
//  PRE_EN       in   1   1 = pre-adder result feeds B1 (OPMODE[4] role)
//  PRE_SUB      in   1   0 = D+B0, 1 = D-B0 (OPMODE[6] role)
//  BCOUT        out  18  B1-stage output, cascade to the next slice and to the multiplier
//  BCOUT_VALID  out  1   BCOUT holds data launched with IN_VALID=1
// BEHAVIOUR
//  - Reset (RSTN=0): B0, D, B1 and all valid flags clear to 0 immediately, independent of CLK.
//    BCOUT=0 and BCOUT_VALID=0 while RSTN=0; first capture is on the first rising CLK after release.
//  - Source mux: bsel = B or BCIN per B_INPUT, evaluated at elaboration; an illegal value gives 0.
//  - B0 stage: b0 = B0REG ? reg(bsel) : bsel. d0 = DREG ? reg(D) : D. Both load only when CE=1.
//  - Pre-adder: pre = PRE_SUB ? d0 - b0 : d0 + b0, 18-bit modulo (wrap, no saturation, no flag).
//    PRE_EN and PRE_SUB are sampled combinationally in the same cycle as b0/d0; they are not registered.
//  - B1 stage: b1_in = PRE_EN ? pre : b0. BCOUT = B1REG ? reg(b1_in) : b1_in. Loads only when CE=1.
//  - Latency: L = B0REG + B1REG cycles of CE=1, range 0..2. With pre-add, the D path uses DREG + B1REG.
//    Matching DREG to B0REG is the user's responsibility; the block does not compensate for a mismatch.
//  - Valid tracker: a shift chain of length L carrying IN_VALID. It advances only on CE=1.
//    L=0 means BCOUT_VALID = IN_VALID combinationally.
//  - CE=0: every register, including the valid chain, holds its value; BCOUT and BCOUT_VALID are stable.
//  - Simultaneous events: RSTN low overrides CE and all data.
//    A PRE_EN change takes effect on the next B1 load, with no bubble.
//  - Wrap-around examples: D=18'h3FFFF plus b0=1 gives 0; D=0 minus b0=1 gives 18'h3FFFF.
//  - Reset mid-stream: in-flight data is discarded. BCOUT_VALID reasserts exactly L enabled cycles
//    after the first post-reset IN_VALID=1.
// CONFIGURATION
//  Macro BCOUT_PARITY_EN.
//  - Defined: adds output BCOUT_PAR (1 bit) = even parity (^) of b1_in.
//    It is registered alongside B1 with the same CE, reset value 0, and the same latency as BCOUT.
//  - Undefined: the port and its logic are absent; all other behaviour is identical.
// TESTING
//  1 Reset: hold RSTN=0 with B=18'h12345 and CE=1 for 3 clocks -> BCOUT=0, BCOUT_VALID=0.
//    Release RSTN -> BCOUT=18'h12345 after 2 clocks (defaults).
//  2 Source: B_INPUT="CASCADE", BCIN=18'h00ABC, B=18'h3FFFF -> BCOUT=18'h00ABC.
//    B_INPUT="FOO" -> BCOUT=0.
//  3 Pre-adder: PRE_EN=1, PRE_SUB=0, D=18'h3FFFF, B=1 -> BCOUT=0 (wrap).
//    PRE_SUB=1, D=5, B=7 -> BCOUT=18'h3FFFE.
//  4 CE stall: stream 1,2,3 with CE=0 for 2 cycles mid-stream -> outputs 1,2,3 in order, none lost.
//    BCOUT_VALID stays frozen during the stall.
//  5 Latency sweep: B0REG/B1REG = 0/0, 0/1, 1/0, 1/1 with a single IN_VALID pulse ->
//    BCOUT_VALID pulse appears 0, 1, 1 and 2 cycles later, respectively.
//  6 Async reset mid-stream: drop RSTN between clock edges -> BCOUT=0 and BCOUT_VALID=0 before the next edge.
//    With BCOUT_PARITY_EN, BCOUT_PAR=1 for B=18'h00007.

Source files
------------

// File: rtl/bcout_cascade_driver.sv
// bcout_cascade_driver: transmit side of the DSP slice B-cascade.
// The selected B source passes through an optional B0 register, an optional D
// register and pre-adder, and then the B1 register to drive BCOUT. A valid flag
// follows the same bypassable stages, so BCOUT_VALID matches BCOUT latency.
// Optional feature: define BCOUT_PARITY_EN to add BCOUT_PAR, the even parity
// of the B1 input, registered alongside B1.
module bcout_cascade_driver #(
  parameter string B_INPUT = "DIRECT",
  parameter int    B0REG   = 1,
  parameter int    DREG    = 1,
  parameter int    B1REG   = 1
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        CE,
  input  logic [17:0] B,
  input  logic [17:0] BCIN,
  input  logic [17:0] D,
  input  logic        IN_VALID,
  input  logic        PRE_EN,
  input  logic        PRE_SUB,
  output logic [17:0] BCOUT,
`ifdef BCOUT_PARITY_EN
  output logic        BCOUT_PAR,
`endif
  output logic        BCOUT_VALID
);

  localparam int W = 18;

  // Source select is resolved at elaboration; unknown names select zero.
  localparam logic [1:0] SRC_SEL = (B_INPUT == "DIRECT")  ? 2'd0 :
                                   (B_INPUT == "CASCADE") ? 2'd1 : 2'd2;
  localparam bit B0_ON = (B0REG != 0);
  localparam bit D_ON  = (DREG  != 0);
  localparam bit B1_ON = (B1REG != 0);

  logic [W-1:0] bsel;
  logic [W-1:0] b0;
  logic [W-1:0] d0;
  logic         v0;
  logic [W-1:0] pre;
  logic [W-1:0] b1_in;
  logic [W-1:0] b1;
  logic         v1;
`ifdef BCOUT_PARITY_EN
  logic         par_in;
  logic         par;
`endif

  assign bsel = (SRC_SEL == 2'd0) ? B :
                (SRC_SEL == 2'd1) ? BCIN : '0;

  // B0 stage: data and its valid flag share the same register/bypass choice.
  if (B0_ON) begin : g_b0_reg
    logic [W-1:0] b0_q;
    logic         v0_q;
    // B0 register and first valid-chain stage, advancing only on CE.
    always_ff @(posedge CLK or negedge RSTN) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (!RSTN) begin
        b0_q <= '0;
        v0_q <= 1'b0;
      end else if (CE) begin
        b0_q <= bsel;
        v0_q <= IN_VALID;
      end
    end
    assign b0 = b0_q;
    assign v0 = v0_q;
  end else begin : g_b0_byp
    assign b0 = bsel;
    assign v0 = IN_VALID;
  end

  // D stage: pre-adder operand, aligned by the user with the B0 choice.
  if (D_ON) begin : g_d_reg
    logic [W-1:0] d_q;
    // D register, advancing only on CE.
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)   d_q <= '0;
      else if (CE) d_q <= D;
    end
    assign d0 = d_q;
  end else begin : g_d_byp
    assign d0 = D;
  end

  // Pre-adder and B1 input select; controls act in the cycle they are presented.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch can form.
    pre   = d0 + b0;
    b1_in = b0;
    if (PRE_SUB) pre = d0 - b0;
    if (PRE_EN)  b1_in = pre;
  end

`ifdef BCOUT_PARITY_EN
  assign par_in = ^b1_in;
`endif

  // B1 stage: output register plus final valid-chain stage.
  if (B1_ON) begin : g_b1_reg
    logic [W-1:0] b1_q;
    logic         v1_q;
`ifdef BCOUT_PARITY_EN
    logic         par_q;
`endif
    // B1 register, valid flag and parity, advancing only on CE.
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        b1_q  <= '0;
        v1_q  <= 1'b0;
`ifdef BCOUT_PARITY_EN
        par_q <= 1'b0;
`endif
      end else if (CE) begin
        b1_q  <= b1_in;
        v1_q  <= v0;
`ifdef BCOUT_PARITY_EN
        par_q <= par_in;
`endif
      end
    end
    assign b1 = b1_q;
    assign v1 = v1_q;
`ifdef BCOUT_PARITY_EN
    assign par = par_q;
`endif
  end else begin : g_b1_byp
    assign b1 = b1_in;
    assign v1 = v0;
`ifdef BCOUT_PARITY_EN
    assign par = par_in;
`endif
  end

  // NOTE: outputs are also forced low by RSTN so fully bypassed builds read zero in reset.
  assign BCOUT       = RSTN ? b1 : '0;
  assign BCOUT_VALID = RSTN & v1;
`ifdef BCOUT_PARITY_EN
  assign BCOUT_PAR   = RSTN & par;
`endif

endmodule

// File: tb/tb_bcout_cascade_driver.sv
// Self-checking bench for bcout_cascade_driver. Six instances with different
// source/latency settings share one input stream; a history-of-enabled-edges
// model predicts every output.
module tb_bcout_cascade_driver;

  localparam int N = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic [17:0] b = '0;
  logic [17:0] bcin = '0;
  logic [17:0] d = '0;
  logic        in_valid = 1'b0;
  logic        pre_en = 1'b0;
  logic        pre_sub = 1'b0;

  logic [17:0] bc [N];
  logic        bv [N];
`ifdef BCOUT_PARITY_EN
  logic        bp [N];
`endif

  // Instance configuration as seen by the model: register flags and source.
  int cfg_b0r [N] = '{1, 1, 1, 0, 0, 1};
  int cfg_dr  [N] = '{1, 1, 1, 0, 0, 1};
  int cfg_b1r [N] = '{1, 1, 1, 0, 1, 0};
  int cfg_src [N] = '{0, 1, 2, 0, 0, 0};   // 0 = B, 1 = BCIN, 2 = zero

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  bcout_cascade_driver #(.B_INPUT("DIRECT"), .B0REG(1), .DREG(1), .B1REG(1)) u_dut (
    .CLK(clk), .RSTN(rst_n), .CE(ce), .B(b), .BCIN(bcin), .D(d), .IN_VALID(in_valid),
    .PRE_EN(pre_en), .PRE_SUB(pre_sub), .BCOUT(bc[0]),
`ifdef BCOUT_PARITY_EN
    .BCOUT_PAR(bp[0]),
`endif
    .BCOUT_VALID(bv[0]));

  bcout_cascade_driver #(.B_INPUT("CASCADE"), .B0REG(1), .DREG(1), .B1REG(1)) u_casc (
    .CLK(clk), .RSTN(rst_n), .CE(ce), .B(b), .BCIN(bcin), .D(d), .IN_VALID(in_valid),
    .PRE_EN(pre_en), .PRE_SUB(pre_sub), .BCOUT(bc[1]),
`ifdef BCOUT_PARITY_EN
    .BCOUT_PAR(bp[1]),
`endif
    .BCOUT_VALID(bv[1]));

  bcout_cascade_driver #(.B_INPUT("FOO"), .B0REG(1), .DREG(1), .B1REG(1)) u_foo (
    .CLK(clk), .RSTN(rst_n), .CE(ce), .B(b), .BCIN(bcin), .D(d), .IN_VALID(in_valid),
    .PRE_EN(pre_en), .PRE_SUB(pre_sub), .BCOUT(bc[2]),
`ifdef BCOUT_PARITY_EN
    .BCOUT_PAR(bp[2]),
`endif
    .BCOUT_VALID(bv[2]));

  bcout_cascade_driver #(.B_INPUT("DIRECT"), .B0REG(0), .DREG(0), .B1REG(0)) u_l00 (
    .CLK(clk), .RSTN(rst_n), .CE(ce), .B(b), .BCIN(bcin), .D(d), .IN_VALID(in_valid),
    .PRE_EN(pre_en), .PRE_SUB(pre_sub), .BCOUT(bc[3]),
`ifdef BCOUT_PARITY_EN
    .BCOUT_PAR(bp[3]),
`endif
    .BCOUT_VALID(bv[3]));

  bcout_cascade_driver #(.B_INPUT("DIRECT"), .B0REG(0), .DREG(0), .B1REG(1)) u_l01 (
    .CLK(clk), .RSTN(rst_n), .CE(ce), .B(b), .BCIN(bcin), .D(d), .IN_VALID(in_valid),
    .PRE_EN(pre_en), .PRE_SUB(pre_sub), .BCOUT(bc[4]),
`ifdef BCOUT_PARITY_EN
    .BCOUT_PAR(bp[4]),
`endif
    .BCOUT_VALID(bv[4]));

  bcout_cascade_driver #(.B_INPUT("DIRECT"), .B0REG(1), .DREG(1), .B1REG(0)) u_l10 (
    .CLK(clk), .RSTN(rst_n), .CE(ce), .B(b), .BCIN(bcin), .D(d), .IN_VALID(in_valid),
    .PRE_EN(pre_en), .PRE_SUB(pre_sub), .BCOUT(bc[5]),
`ifdef BCOUT_PARITY_EN
    .BCOUT_PAR(bp[5]),
`endif
    .BCOUT_VALID(bv[5]));

  // Model: inputs as sampled at the last two enabled edges since reset.
  typedef struct packed {
    logic [17:0] b;
    logic [17:0] bcin;
    logic [17:0] d;
    logic        v;
    logic        pe;
    logic        ps;
  } rec_t;

  rec_t hist [1:2];

  function automatic rec_t cur_rec();
    rec_t r;
    r.b = b; r.bcin = bcin; r.d = d; r.v = in_valid; r.pe = pre_en; r.ps = pre_sub;
    return r;
  endfunction

  // k = 0: present inputs; k = n: inputs at the n-th most recent enabled edge.
  function automatic rec_t hget(int k);
    if (k == 0) return cur_rec();
    return hist[k];
  endfunction

  function automatic logic [17:0] src_of(int s, rec_t r);
    if (s == 0) return r.b;
    if (s == 1) return r.bcin;
    return 18'h0;
  endfunction

  function automatic logic [17:0] exp_out(int i);
    rec_t        rb1 = hget(cfg_b1r[i]);
    rec_t        rb0 = hget(cfg_b1r[i] + cfg_b0r[i]);
    rec_t        rd  = hget(cfg_b1r[i] + cfg_dr[i]);
    logic [17:0] b0v = src_of(cfg_src[i], rb0);
    logic [17:0] r;
    if (!rst_n)      r = 18'h0;
    else if (!rb1.pe) r = b0v;
    else if (rb1.ps)  r = rd.d - b0v;
    else              r = rd.d + b0v;
    return r;
  endfunction

  function automatic logic exp_vld(int i);
    rec_t rv = hget(cfg_b1r[i] + cfg_b0r[i]);
    return rst_n & rv.v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_rst(input logic v);
    rst_n = v;
    if (!v) begin
      hist[1] = '0;
      hist[2] = '0;
    end
  endtask

  // One clock: record the edge in the model if it will load, then step past it.
  task automatic tick();
    if (ce && rst_n) begin
      hist[2] = hist[1];
      hist[1] = cur_rec();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_u%0d_out", tag, i), {14'h0, bc[i]}, {14'h0, exp_out(i)});
      chk($sformatf("%s_u%0d_vld", tag, i), {31'h0, bv[i]}, {31'h0, exp_vld(i)});
`ifdef BCOUT_PARITY_EN
      chk($sformatf("%s_u%0d_par", tag, i), {31'h0, bp[i]}, {31'h0, ^exp_out(i)});
`endif
    end
  endtask

  int lat [N] = '{2, 2, 2, 0, 1, 1};
  logic [17:0] got [$];
  int ce_seq [7] = '{1, 1, 0, 0, 1, 1, 1};
  int b_seq  [7] = '{1, 2, 9, 9, 3, 0, 0};
  int v_seq  [7] = '{1, 1, 1, 1, 1, 0, 0};

  initial begin
    set_rst(1'b0);

    // Reset holds outputs low while data and CE are active.
    ce = 1'b1; b = 18'h12345; in_valid = 1'b1;
    repeat (3) begin
      tick();
      check_all("t1_rst");
    end
    chk("t1_rst_bcout", {14'h0, bc[0]}, 32'h0);
    chk("t1_rst_valid", {31'h0, bv[0]}, 32'h0);
    set_rst(1'b1);
    tick(); check_all("t1_rel1");
    chk("t1_rel1_valid", {31'h0, bv[0]}, 32'h0);
    tick(); check_all("t1_rel2");
    chk("t1_lat2_bcout", {14'h0, bc[0]}, 32'h12345);
    chk("t1_lat2_valid", {31'h0, bv[0]}, 32'h1);

    // Source selection.
    bcin = 18'h00ABC; b = 18'h3FFFF;
    tick(); check_all("t2a");
    tick(); check_all("t2b");
    chk("t2_cascade", {14'h0, bc[1]}, 32'h00ABC);
    chk("t2_illegal", {14'h0, bc[2]}, 32'h0);

    // Pre-adder wrap-around in both directions.
    pre_en = 1'b1; pre_sub = 1'b0; d = 18'h3FFFF; b = 18'h1;
    tick(); check_all("t3a");
    tick(); check_all("t3b");
    chk("t3_add_wrap", {14'h0, bc[0]}, 32'h0);
    pre_sub = 1'b1; d = 18'h5; b = 18'h7;
    tick(); check_all("t3c");
    tick(); check_all("t3d");
    chk("t3_sub_wrap", {14'h0, bc[0]}, 32'h3FFFE);

    // CE stall mid-stream: nothing lost, outputs frozen.
    pre_en = 1'b0; pre_sub = 1'b0; d = '0; bcin = '0; in_valid = 1'b0; b = '0;
    tick(); tick(); check_all("t4_flush");
    for (int s = 0; s < 7; s++) begin
      ce = ce_seq[s][0]; b = 18'(b_seq[s]); in_valid = v_seq[s][0];
      tick();
      check_all($sformatf("t4_s%0d", s));
      if (ce_seq[s] != 0 && bv[0]) got.push_back(bc[0]);
      if (ce_seq[s] == 0) begin
        chk("t4_frozen_out", {14'h0, bc[0]}, 32'h1);
        chk("t4_frozen_vld", {31'h0, bv[0]}, 32'h1);
      end
    end
    chk("t4_count", got.size(), 32'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("t4_order%0d", k), (k < got.size()) ? {14'h0, got[k]} : 32'hDEAD, k + 1);

    // Latency sweep with a single valid pulse.
    ce = 1'b1; in_valid = 1'b0; b = '0;
    repeat (3) tick();
    b = 18'h155; in_valid = 1'b1;
    for (int off = 0; off < 4; off++) begin
      check_all($sformatf("t5_off%0d", off));
      for (int i = 0; i < N; i++)
        chk($sformatf("t5_lat_u%0d_off%0d", i, off), {31'h0, bv[i]}, {31'h0, (off == lat[i])});
      tick();
      in_valid = 1'b0;
    end

    // Asynchronous reset between edges, then restart with parity data.
    b = 18'h00007; in_valid = 1'b1;
    tick(); check_all("t6a");
    tick(); check_all("t6b");
    #2;
    set_rst(1'b0);
    check_all("t6_async");
    chk("t6_async_out", {14'h0, bc[0]}, 32'h0);
    chk("t6_async_vld", {31'h0, bv[0]}, 32'h0);
    tick(); check_all("t6_held");
    set_rst(1'b1);
    tick(); check_all("t6_r1");
    chk("t6_r1_vld", {31'h0, bv[0]}, 32'h0);
    tick(); check_all("t6_r2");
    chk("t6_r2_vld", {31'h0, bv[0]}, 32'h1);
    chk("t6_r2_out", {14'h0, bc[0]}, 32'h7);
`ifdef BCOUT_PARITY_EN
    chk("t6_par", {31'h0, bp[0]}, 32'h1);
`endif

    // Randomized traffic with stalls and occasional resets.
    for (int n = 0; n < 400; n++) begin
      tick();
      b        = 18'($urandom);
      bcin     = 18'($urandom);
      d        = 18'($urandom);
      in_valid = 1'($urandom);
      pre_en   = 1'($urandom);
      pre_sub  = 1'($urandom);
      ce       = ($urandom_range(0, 9) < 8);
      if (rst_n && $urandom_range(0, 49) == 0) set_rst(1'b0);
      else if (!rst_n && $urandom_range(0, 3) == 0) set_rst(1'b1);
      check_all("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
